servo_ramp_ctrl: RTL and testbench
==================================

Name: servo_ramp_ctrl

Overview:
Position sequencer that drives the `duty` input of the `servo` PWM driver. It accepts target-position commands over a valid/ready handshake and ramps `duty` toward each target in fixed steps. `duty` changes only on 20 ms frame boundaries, so the driver never sees a mid-period glitch. It reports progress and completion to the system logic.

Parameters:
- FRAME_TICKS, 500000, clocks per PWM frame (20 ms at 25 MHz)
- DUTY_W, 20, width of duty/target values
- MIN_DUTY, 25000, lowest legal duty (1 ms, 0 deg)
- MAX_DUTY, 50000, highest legal duty (2 ms, 180 deg)
- CENTER_DUTY, 37500, duty after reset (1.5 ms)
- STEP_W, 16, width of step size
- DIV_W, 8, width of frames-per-step divider

Ports:
- clk  in  1  system clock, 25 MHz
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_target  in  DUTY_W  requested duty
- cmd_step  in  STEP_W  duty increment per update; 0 treated as 1
- cmd_div  in  DIV_W  frames between updates; 0 treated as 1
- abort  in  1  stop ramp, hold current duty
- duty  out  DUTY_W  to servo.duty
- frame_tick  out  1  one-cycle pulse on last clock of each frame
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse when target reached or aborted
- clamped  out  1  sticky; last accepted target was outside [MIN,MAX]; cleared on next accept

Behaviour:
- Reset (rst_n=0 at posedge): duty=CENTER_DUTY, state IDLE, frame counter=0, divider=0, frame_tick=0, busy=0, done=0, clamped=0, cmd_ready=0 during the reset cycle.
- Frame counter:
  - Free-running 0..FRAME_TICKS-1, then wraps to 0.
  - frame_tick=1 while count==FRAME_TICKS-1.
  - Independent of the FSM.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch target, step and div (clamped as below) and go to RAMP.
    - If the clamped target equals current duty, stay in IDLE and pulse done next cycle.
  - RAMP: busy=1, cmd_ready=0. On each frame_tick, divider increments.
    - When divider reaches div_eff-1, divider resets to 0 and duty moves one step toward target.
    - The step saturates at the target; duty never overshoots.
    - When the updated duty equals target, go to DONE.
  - DONE: one cycle; done=1, busy=0; then IDLE.
- Update timing:
  - duty changes only on the clock edge where frame_tick=1, so the new value is stable from frame count 0.
  - First update occurs div_eff frame ticks after accept.
- Arithmetic:
  - Target is clamped to [MIN_DUTY,MAX_DUTY]; clamped=1 if clamping occurred.
  - Step arithmetic uses DUTY_W+1 bits, with no wrap below 0 or above MAX.
- abort:
  - In RAMP: go to DONE next edge and freeze duty at its current value.
  - abort wins over a simultaneous frame_tick update (no step taken).
  - Ignored in IDLE and DONE.
- Commands presented while not ready are held by the requester (standard valid/ready). cmd_valid and abort in IDLE in the same cycle: the command is accepted.
- Reset mid-RAMP: immediate return to reset values; the in-flight command is discarded.

Optional Feature:
- Macro SERVO_SWEEP_EN.
- Defined:
  - Adds input port sweep_en.
  - While sweep_en=1 and no cmd_valid in IDLE, the controller self-issues alternating targets MAX_DUTY then MIN_DUTY, using step=250 and div=100.
  - External commands have priority.
- Undefined: port absent; the controller moves only on external commands.

Decomposition:
- Package servo_pkg:
  - DUTY_W, MIN_DUTY, MAX_DUTY, CENTER_DUTY, FRAME_TICKS constants
  - duty_t typedef
  - ramp_state_t enum {IDLE, RAMP, DONE}
- Sub-module servo_frame_timer (frame counter plus frame_tick), reusable by the servo driver.

Test Plan (benches use FRAME_TICKS=100):
- Reset release -> duty=37500, cmd_ready=1, busy=0; first frame_tick at cycle 99 after release.
- Command target=40000, step=250, div=1 -> 10 updates, one per frame_tick, duty=40000 after the 10th tick; done pulses once; busy drops with it.
- target=37600, step=250 from 37500 -> single update to exactly 37600 (no overshoot to 37750); done pulses.
- target=60000 -> clamped=1, ramp ends at 50000. Next command target=30000 -> clamped=0.
- abort in the same cycle as a frame_tick mid-ramp at duty=38500 -> duty stays 38500, done pulses, IDLE.
- rst_n=0 for 1 cycle mid-ramp -> duty=37500, state IDLE, frame count restarts at 0. With SERVO_SWEEP_EN and sweep_en=1 -> duty ramps to 50000, then back to 25000, repeating.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo position sequencer and PWM driver.
// Optional feature macro: SERVO_SWEEP_EN (autonomous end-to-end sweep).
package servo_pkg;

   localparam int DUTY_W      = 20;
   localparam int MIN_DUTY    = 25000;   // 1.0 ms, 0 deg
   localparam int MAX_DUTY    = 50000;   // 2.0 ms, 180 deg
   localparam int CENTER_DUTY = 37500;   // 1.5 ms, power-on position
   localparam int FRAME_TICKS = 500000;  // 20 ms at 25 MHz
   localparam int STEP_W      = 16;
   localparam int DIV_W       = 8;

   // Self-issued sweep profile (SERVO_SWEEP_EN builds only)
   localparam int SWEEP_STEP  = 250;
   localparam int SWEEP_DIV   = 100;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } ramp_state_t;

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last clock of a frame.
// Shared between the ramp sequencer and the servo PWM driver so both agree
// on frame boundaries.
module servo_frame_timer #(
   parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   output logic frame_tick
);

   localparam int              CW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CW-1:0]   LAST = CW'(FRAME_TICKS - 1);
   localparam logic [CW-1:0]   ONE  = CW'(1);

   logic [CW-1:0] count;

   // Count 0..FRAME_TICKS-1 and wrap; runs regardless of sequencer state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      if (!rst_n)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + ONE;
   end

   assign frame_tick = (count == LAST);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo position sequencer: accepts target commands over valid/ready and
// ramps duty toward each target in fixed steps, updating only on frame
// boundaries so the PWM driver never sees a mid-period change.
// Optional feature macro: SERVO_SWEEP_EN adds sweep_en, which self-issues
// alternating MAX/MIN targets while idle and no external command is present.
module servo_ramp_ctrl
   import servo_pkg::*;
#(
   parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS,
   parameter int DUTY_W      = servo_pkg::DUTY_W,
   parameter int MIN_DUTY    = servo_pkg::MIN_DUTY,
   parameter int MAX_DUTY    = servo_pkg::MAX_DUTY,
   parameter int CENTER_DUTY = servo_pkg::CENTER_DUTY,
   parameter int STEP_W      = servo_pkg::STEP_W,
   parameter int DIV_W       = servo_pkg::DIV_W
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef SERVO_SWEEP_EN
   input  logic              sweep_en,
`endif
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [STEP_W-1:0] cmd_step,
   input  logic [DIV_W-1:0]  cmd_div,
   input  logic              abort,
   output logic [DUTY_W-1:0] duty,
   output logic              frame_tick,
   output logic              busy,
   output logic              done,
   output logic              clamped
);

   localparam int                EXT_W = DUTY_W + 1;
   localparam logic [DUTY_W-1:0] MIN_D = DUTY_W'(MIN_DUTY);
   localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] CTR_D = DUTY_W'(CENTER_DUTY);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

   ramp_state_t       state;
   logic [DUTY_W-1:0] target;
   logic [STEP_W-1:0] step;
   logic [DIV_W-1:0]  div_eff;
   logic [DIV_W-1:0]  div_cnt;

   // Command source after optional sweep muxing
   logic              src_valid;
   logic [DUTY_W-1:0] src_target;
   logic [STEP_W-1:0] src_step;
   logic [DIV_W-1:0]  src_div;

   // Command after clamping / zero substitution
   logic              accept;
   logic [DUTY_W-1:0] acc_target;
   logic              acc_clamped;
   logic [STEP_W-1:0] acc_step;
   logic [DIV_W-1:0]  acc_div;

   logic [DUTY_W-1:0] next_duty;
   logic [EXT_W-1:0]  duty_x, target_x, step_x, up_sum, down_lim;

   servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_frame_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick)
   );

`ifdef SERVO_SWEEP_EN
   logic sweep_hi;
   logic sweep_issue;

   // Choose the command source: external commands win over the sweep.
   always_comb begin
      src_valid   = cmd_valid;
      src_target  = cmd_target;
      src_step    = cmd_step;
      src_div     = cmd_div;
      sweep_issue = 1'b0;
      if (!cmd_valid && sweep_en) begin
         sweep_issue = 1'b1;
         src_valid   = 1'b1;
         src_target  = sweep_hi ? MAX_D : MIN_D;
         src_step    = STEP_W'(SWEEP_STEP);
         src_div     = DIV_W'(SWEEP_DIV);
      end
   end

   // Alternate sweep direction each time a sweep target is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sweep_hi <= 1'b1;
      else if (state == IDLE && sweep_issue)
         sweep_hi <= ~sweep_hi;
   end
`else
   // Only external commands move the servo.
   always_comb begin
      src_valid  = cmd_valid;
      src_target = cmd_target;
      src_step   = cmd_step;
      src_div    = cmd_div;
   end
`endif

   // Clamp the requested target into the legal range and map 0 step/div to 1.
   always_comb begin
      accept      = src_valid && (state == IDLE);
      acc_target  = src_target;
      acc_clamped = 1'b0;
      if (src_target < MIN_D) begin
         acc_target  = MIN_D;
         acc_clamped = 1'b1;
      end else if (src_target > MAX_D) begin
         acc_target  = MAX_D;
         acc_clamped = 1'b1;
      end
      acc_step = (src_step == '0) ? STEP_ONE : src_step;
      acc_div  = (src_div  == '0) ? DIV_ONE  : src_div;
   end

   // One step toward target, computed one bit wider and saturated at target.
   always_comb begin
      duty_x   = {1'b0, duty};
      target_x = {1'b0, target};
      step_x   = EXT_W'(step);
      up_sum   = duty_x + step_x;
      down_lim = target_x + step_x;
      if (target > duty)
         next_duty = (up_sum >= target_x) ? target : duty + DUTY_W'(step);
      else
         next_duty = (duty_x <= down_lim) ? target : duty - DUTY_W'(step);
   end

   // Sequencer FSM: accept in IDLE, step on frame ticks in RAMP, pulse in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         duty    <= CTR_D;
         target  <= CTR_D;
         step    <= STEP_ONE;
         div_eff <= DIV_ONE;
         div_cnt <= '0;
         done    <= 1'b0;
         clamped <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  target  <= acc_target;
                  step    <= acc_step;
                  div_eff <= acc_div;
                  div_cnt <= '0;
                  clamped <= acc_clamped;
                  if (acc_target == duty)
                     done <= 1'b1;
                  else
                     state <= RAMP;
               end
            end
            RAMP: begin
               if (abort) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  div_cnt <= '0;
               end else if (frame_tick) begin
                  if (div_cnt == div_eff - DIV_ONE) begin
                     div_cnt <= '0;
                     duty    <= next_duty;
                     if (next_duty == target) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_ONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Ready is forced low while reset is being applied, not just after it.
   assign cmd_ready = (state == IDLE) && rst_n;
   assign busy      = (state == RAMP);

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl with a 100-clock frame.
module tb_servo_ramp_ctrl;
   import servo_pkg::*;

   localparam int FT = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        abort = 1'b0;
   logic [19:0] cmd_target = '0;
   logic [15:0] cmd_step = '0;
   logic [7:0]  cmd_div = '0;
`ifdef SERVO_SWEEP_EN
   logic        sweep_en = 1'b0;
`endif
   logic        cmd_ready, frame_tick, busy, done, clamped;
   logic [19:0] duty;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [19:0] target;
      logic [15:0] step;
      logic [7:0]  div;
      logic [19:0] exp_duty;
      logic        exp_clamped;
      int          exp_updates;
   } vec_t;

   vec_t        vecs [8];
   vec_t        sb_q [$];
   logic [19:0] prev_duty;
   logic        prev_tick;

   servo_ramp_ctrl #(.FRAME_TICKS(FT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef SERVO_SWEEP_EN
      .sweep_en   (sweep_en),
`endif
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .cmd_div    (cmd_div),
      .abort      (abort),
      .duty       (duty),
      .frame_tick (frame_tick),
      .busy       (busy),
      .done       (done),
      .clamped    (clamped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hold reset for cyc cycles, check reset outputs, release and time the first tick.
   task automatic reset_seq(input int cyc);
      int n;
      rst_n = 1'b0;
      repeat (cyc) @(negedge clk);
      check("rst_ready_low", cmd_ready, 0);
      check("rst_duty", duty, 37500);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", cmd_ready, 1);
      check("rel_clamped", clamped, 0);
      n = 0;
      while (!frame_tick && n < 3 * FT) begin
         @(negedge clk);
         n++;
      end
      check("first_tick_cycle", n, FT - 1);
      check("tick_duty_hold", duty, 37500);
      check("tick_busy", busy, 0);
   endtask

   task automatic drive_cmd(input vec_t v, input logic with_abort);
      int n = 0;
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", cmd_ready, 1);
      cmd_target = v.target;
      cmd_step   = v.step;
      cmd_div    = v.div;
      cmd_valid  = 1'b1;
      abort      = with_abort;
      sb_q.push_back(v);
      prev_duty = duty;
      prev_tick = frame_tick;
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = 1'b0;
   endtask

   // Pop the oldest expectation and follow the DUT until its done pulse.
   task automatic wait_result(input string name);
      vec_t e;
      int   upd = 0, ticks = 0, glitch = 0, n = 0, div_e;
      logic got = 1'b0;
      e = sb_q.pop_front();
      while (n < 5000) begin
         if (duty !== prev_duty) begin
            upd++;
            if (!prev_tick) glitch++;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         if (frame_tick) ticks++;
         prev_duty = duty;
         prev_tick = frame_tick;
         @(negedge clk);
         n++;
      end
      check({name, "_done_seen"}, got, 1);
      check({name, "_duty"}, duty, e.exp_duty);
      check({name, "_clamped"}, clamped, e.exp_clamped);
      check({name, "_updates"}, upd, e.exp_updates);
      check({name, "_frame_aligned"}, glitch, 0);
      check({name, "_busy_at_done"}, busy, 0);
      div_e = (e.div == 0) ? 1 : int'(e.div);
      if (e.exp_updates > 0)
         check({name, "_ticks"}, ticks, e.exp_updates * div_e);
      @(negedge clk);
      check({name, "_done_single"}, done, 0);
      check({name, "_ready_after"}, cmd_ready, 1);
   endtask

   initial begin
      int n;
      //           target  step   div exp_duty clamp updates
      vecs[0] = '{20'd40000, 16'd250,   8'd1, 20'd40000, 1'b0, 10};
      vecs[1] = '{20'd37500, 16'd250,   8'd1, 20'd37500, 1'b0, 10};
      vecs[2] = '{20'd37600, 16'd250,   8'd1, 20'd37600, 1'b0, 1};
      vecs[3] = '{20'd60000, 16'd5000,  8'd0, 20'd50000, 1'b1, 3};
      vecs[4] = '{20'd30000, 16'd10000, 8'd2, 20'd30000, 1'b0, 2};
      vecs[5] = '{20'd10,    16'd65535, 8'd3, 20'd25000, 1'b1, 1};
      vecs[6] = '{20'd25000, 16'd250,   8'd1, 20'd25000, 1'b0, 0};
      vecs[7] = '{20'd25003, 16'd0,     8'd1, 20'd25003, 1'b0, 3};

      reset_seq(3);

      for (int i = 0; i < 8; i++) begin
         drive_cmd(vecs[i], 1'b0);
         check($sformatf("vec%0d_busy", i), busy, (vecs[i].exp_updates > 0) ? 1 : 0);
         wait_result($sformatf("vec%0d", i));
      end

      // Reset pulse mid-ramp: the in-flight command is dropped.
      drive_cmd('{20'd30000, 16'd250, 8'd1, 20'd30000, 1'b0, 20}, 1'b0);
      n = 0;
      while (duty != 20'd25503 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("midramp_progress", duty, 25503);
      sb_q.delete();
      reset_seq(1);

      // Abort coinciding with a frame tick at duty 38500.
      drive_cmd('{20'd40000, 16'd250, 8'd1, 20'd38500, 1'b0, 0}, 1'b0);
      n = 0;
      while (duty != 20'd38500 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach_38500", duty, 38500);
      n = 0;
      while (!frame_tick && n < 2 * FT) begin
         @(negedge clk);
         n++;
      end
      check("abort_tick_found", frame_tick, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      prev_duty = duty;
      prev_tick = 1'b0;
      wait_result("abort");
      repeat (2 * FT) @(negedge clk);
      check("abort_hold_duty", duty, 38500);
      check("abort_idle_busy", busy, 0);

      // Command and abort together in IDLE: the command wins.
      drive_cmd('{20'd38750, 16'd250, 8'd1, 20'd38750, 1'b0, 1}, 1'b1);
      wait_result("idle_abort_cmd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
